// File: rtl/timer0_peripheral.sv
// Timer0 block: owns TMR0 and OPTION_REG, with a shared prescaler, T0CKI
// synchronizer/edge detector, post-write increment inhibit and an overflow pulse.
module timer0_peripheral #(
  parameter int PRESCALER_WIDTH = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       inst_cycle_en,
  input  logic [7:0] data_in,
  input  logic       tmr0_reg_wr_en,
  input  logic       option_reg_wr_en,
  input  logic       t0cki,
  output logic [7:0] tmr0_reg_val,
  output logic [7:0] option_reg_val,
  output logic       t0if_set
);

  logic [7:0]                 tmr0_q, tmr0_d;
  logic [7:0]                 option_q, option_d;
  logic [PRESCALER_WIDTH-1:0] pre_q, pre_d;
  logic [1:0]                 inh_q, inh_d;
  logic                       t0if_q, t0if_d;
  logic                       sync1_q, sync1_d;
  logic                       sync2_q, sync2_d;
  logic                       hist_q, hist_d;

  logic                       t0cs, t0se, psa;
  logic [2:0]                 ps;
  logic                       t0_edge, src_tick, tick, inc;
  logic [PRESCALER_WIDTH-1:0] wrap_val;

  // Terminal prescaler count for a 1:2^(ps+1) ratio: the low ps+1 bits set.
  function automatic logic [PRESCALER_WIDTH-1:0] ratio_mask(input logic [2:0] sel);
    logic [PRESCALER_WIDTH-1:0] m;
    for (int i = 0; i < PRESCALER_WIDTH; i++) begin
      m[i] = (i <= int'(sel));
    end
    return m;
  endfunction

  assign t0cs     = option_q[5];
  assign t0se     = option_q[4];
  assign psa      = option_q[3];
  assign ps       = option_q[2:0];
  assign wrap_val = ratio_mask(ps);

  always_comb begin
    option_d = option_q;
    tmr0_d   = tmr0_q;
    pre_d    = pre_q;
    inh_d    = inh_q;
    t0if_d   = 1'b0;
    sync1_d  = t0cki;
    sync2_d  = sync1_q;
    hist_d   = sync2_q;

    t0_edge  = t0se ? (hist_q & ~sync2_q) : (sync2_q & ~hist_q);
    src_tick = t0cs ? t0_edge : inst_cycle_en;
    tick     = src_tick && (inh_q == 2'd0);
    inc      = 1'b0;

    if (tick) begin
      if (psa) begin
        inc = 1'b1;
      end else if (pre_q == wrap_val) begin
        pre_d = '0;
        inc   = 1'b1;
      end else begin
        pre_d = pre_q + 1'b1;
      end
    end
    if (psa) begin
      pre_d = '0;
    end

    if (inc) begin
      tmr0_d = tmr0_q + 8'd1;
      t0if_d = (tmr0_q == 8'hFF);
    end

    if ((inh_q != 2'd0) && inst_cycle_en) begin
      inh_d = inh_q - 2'd1;
    end

    // The tick above was already resolved with the old settings; a write only clears the count.
    if (option_reg_wr_en) begin
      option_d = data_in;
      pre_d    = '0;
    end

    if (tmr0_reg_wr_en) begin
      tmr0_d = data_in;
      pre_d  = '0;
      inh_d  = 2'd2;
      t0if_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tmr0_q   <= 8'h00;
      option_q <= 8'hFF;
      pre_q    <= '0;
      inh_q    <= 2'd0;
      t0if_q   <= 1'b0;
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      hist_q   <= 1'b0;
    end else begin
      tmr0_q   <= tmr0_d;
      option_q <= option_d;
      pre_q    <= pre_d;
      inh_q    <= inh_d;
      t0if_q   <= t0if_d;
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      hist_q   <= hist_d;
    end
  end

  assign tmr0_reg_val   = tmr0_q;
  assign option_reg_val = option_q;
  assign t0if_set       = t0if_q;

endmodule

// File: tb/tb_timer0_peripheral.sv
// Bench for timer0_peripheral: directed scenarios plus randomized traffic, all
// checked every cycle against a behavioural model of the timer.
module tb_timer0_peripheral;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       inst_cycle_en = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic       tmr0_reg_wr_en = 1'b0;
  logic       option_reg_wr_en = 1'b0;
  logic       t0cki = 1'b0;
  logic [7:0] tmr0_reg_val;
  logic [7:0] option_reg_val;
  logic       t0if_set;

  timer0_peripheral #(.PRESCALER_WIDTH(8)) dut (
    .clk             (clk),
    .rst             (rst),
    .inst_cycle_en   (inst_cycle_en),
    .data_in         (data_in),
    .tmr0_reg_wr_en  (tmr0_reg_wr_en),
    .option_reg_wr_en(option_reg_wr_en),
    .t0cki           (t0cki),
    .tmr0_reg_val    (tmr0_reg_val),
    .option_reg_val  (option_reg_val),
    .t0if_set        (t0if_set)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int pulses   = 0;

  // Behavioural model state (reset values)
  int         m_tmr = 0;
  logic [7:0] m_opt = 8'hFF;
  int         m_pre = 0;
  int         m_inh = 0;
  bit         m_t0if = 1'b0;
  bit         smp1 = 1'b0, smp2 = 1'b0, smp3 = 1'b0;
  bit         m_rise, m_fall, m_tick, m_inc;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%02h, expected 0x%02h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: smpN holds the pin as sampled N edges ago; the synchronized pin lags two edges.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_tmr = 0; m_opt = 8'hFF; m_pre = 0; m_inh = 0; m_t0if = 1'b0;
      smp1 = 1'b0; smp2 = 1'b0; smp3 = 1'b0;
    end else begin
      m_rise = smp2 && !smp3;
      m_fall = !smp2 && smp3;
      m_tick = m_opt[5] ? (m_opt[4] ? m_fall : m_rise) : inst_cycle_en;
      m_inc  = 1'b0;
      if (m_tick && m_inh == 0) begin
        if (m_opt[3]) m_inc = 1'b1;
        else begin
          m_pre++;
          if (m_pre == (2 << m_opt[2:0])) begin
            m_pre = 0;
            m_inc = 1'b1;
          end
        end
      end
      if (m_opt[3]) m_pre = 0;
      m_t0if = m_inc && (m_tmr == 255) && !tmr0_reg_wr_en;
      if (m_inc) m_tmr = (m_tmr + 1) % 256;
      if (inst_cycle_en && m_inh > 0) m_inh--;
      if (option_reg_wr_en) begin m_opt = data_in; m_pre = 0; end
      if (tmr0_reg_wr_en) begin m_tmr = data_in; m_pre = 0; m_inh = 2; end
      smp3 = smp2; smp2 = smp1; smp1 = t0cki;
    end
  end

  always @(negedge clk) begin
    chk("tmr0", tmr0_reg_val, m_tmr[7:0]);
    chk("option", option_reg_val, m_opt);
    chk("t0if", {7'b0, t0if_set}, {7'b0, m_t0if});
    if (t0if_set === 1'b1) begin
      pulses++;
      chk("t0if_at_zero", tmr0_reg_val, 8'h00);
    end
  end

  task automatic drive(input logic ice, input logic wt, input logic wo, input logic [7:0] d);
    @(negedge clk);
    inst_cycle_en    = ice;
    tmr0_reg_wr_en   = wt;
    option_reg_wr_en = wo;
    data_in          = d;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, 8'h00);
  endtask

  task automatic strobes(input int n);
    for (int i = 0; i < n; i++) begin
      drive(1'b1, 1'b0, 1'b0, 8'h00);
      idle(3);
    end
  endtask

  task automatic pin_hold(input logic v, input int n);
    t0cki = v;
    idle(n);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int hold;
    logic ice, wt, wo;

    // Reset values
    repeat (3) @(negedge clk);
    #1;
    chk("reset_tmr0", tmr0_reg_val, 8'h00);
    chk("reset_option", option_reg_val, 8'hFF);
    chk("reset_t0if", {7'b0, t0if_set}, 8'h00);
    rst = 1'b1;
    idle(2);

    // Bypassed prescaler, 300 instruction cycles
    drive(1'b0, 1'b0, 1'b1, 8'h08);
    pulses = 0;
    strobes(300);
    chk("count300", tmr0_reg_val, 8'h2C);
    chk("ovf_count300", pulses[7:0], 8'd1);

    // 1:8 prescaler
    drive(1'b0, 1'b1, 1'b0, 8'h00);
    strobes(2);
    chk("inhibit_hold0", tmr0_reg_val, 8'h00);
    drive(1'b0, 1'b0, 1'b1, 8'h02);
    strobes(64);
    chk("ps8_64", tmr0_reg_val, 8'h08);
    strobes(5);
    drive(1'b0, 1'b0, 1'b1, 8'h02);
    strobes(7);
    chk("ps8_cleared_7", tmr0_reg_val, 8'h08);
    strobes(1);
    chk("ps8_cleared_8", tmr0_reg_val, 8'h09);

    // Write inhibit window and overflow
    drive(1'b0, 1'b0, 1'b1, 8'h08);
    drive(1'b0, 1'b1, 1'b0, 8'hFE);
    strobes(1);
    chk("inh_s1", tmr0_reg_val, 8'hFE);
    strobes(1);
    chk("inh_s2", tmr0_reg_val, 8'hFE);
    strobes(1);
    chk("inh_s3", tmr0_reg_val, 8'hFF);
    drive(1'b1, 1'b0, 1'b0, 8'h00);
    chk("inh_s4_tmr0", tmr0_reg_val, 8'h00);
    chk("inh_s4_t0if", {7'b0, t0if_set}, 8'h01);
    idle(3);

    // Write beats increment at 0xFF
    drive(1'b0, 1'b1, 1'b0, 8'hFF);
    strobes(2);
    pulses = 0;
    drive(1'b1, 1'b1, 1'b0, 8'h10);
    chk("wr_wins_tmr0", tmr0_reg_val, 8'h10);
    chk("wr_wins_t0if", {7'b0, t0if_set}, 8'h00);
    idle(3);
    strobes(2);
    chk("wr_wins_pulses", pulses[7:0], 8'd0);

    // T0CKI rising edges
    drive(1'b0, 1'b0, 1'b1, 8'h28);
    drive(1'b0, 1'b1, 1'b0, 8'h00);
    strobes(2);
    for (int i = 0; i < 5; i++) begin
      pin_hold(1'b1, 2);
      chk("rise_before", tmr0_reg_val, 8'(i));
      idle(1);
      chk("rise_after", tmr0_reg_val, 8'(i + 1));
      pin_hold(1'b0, 3);
    end
    idle(4);
    chk("rise_total", tmr0_reg_val, 8'h05);

    // T0CKI falling edges
    drive(1'b0, 1'b0, 1'b1, 8'h38);
    drive(1'b0, 1'b1, 1'b0, 8'h00);
    strobes(2);
    for (int i = 0; i < 5; i++) begin
      pin_hold(1'b1, 3);
      chk("fall_high", tmr0_reg_val, 8'(i));
      pin_hold(1'b0, 2);
      chk("fall_before", tmr0_reg_val, 8'(i));
      idle(1);
      chk("fall_after", tmr0_reg_val, 8'(i + 1));
    end
    idle(4);
    chk("fall_total", tmr0_reg_val, 8'h05);

    // Randomized traffic, model-checked each cycle
    hold = 0;
    for (int i = 0; i < 3000; i++) begin
      if (hold == 0) begin
        t0cki = 1'($urandom_range(0, 1));
        hold  = $urandom_range(1, 4);
      end
      hold--;
      ice = ($urandom_range(0, 2) == 0);
      wt  = ($urandom_range(0, 39) == 0);
      wo  = ($urandom_range(0, 29) == 0);
      drive(ice, wt, wo, 8'($urandom_range(0, 255)));
    end
    t0cki = 1'b0;
    idle(4);

    // Async reset mid-count
    drive(1'b0, 1'b0, 1'b1, 8'h07);
    drive(1'b0, 1'b1, 1'b0, 8'h7A);
    strobes(22);
    chk("pre_reset_tmr0", tmr0_reg_val, 8'h7A);
    #2;
    rst = 1'b0;
    #1;
    chk("async_rst_tmr0", tmr0_reg_val, 8'h00);
    chk("async_rst_option", option_reg_val, 8'hFF);
    chk("async_rst_t0if", {7'b0, t0if_set}, 8'h00);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    idle(1);
    chk("post_rst_tmr0", tmr0_reg_val, 8'h00);
    drive(1'b0, 1'b0, 1'b1, 8'h08);
    strobes(3);
    chk("resume_tmr0", tmr0_reg_val, 8'h03);

    idle(2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
